// File: rtl/dsp_cfg_mgmt_responder_pkg.sv
// Shared definitions for the config-management responder: FSM states,
// register DW addresses and writable-bit masks.
package dsp_cfg_mgmt_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [9:0] DW_ID    = 10'd0;
  localparam logic [9:0] DW_CMD   = 10'd1;
  localparam logic [9:0] DW_CLASS = 10'd2;
  localparam logic [9:0] DW_HDR   = 10'd3;
  localparam logic [9:0] DW_BUS   = 10'd6;

  localparam logic [31:0] HDR_TYPE1   = 32'h0001_0000;
  localparam logic [15:0] CMD_WR_MASK = 16'h0407;
  localparam logic [31:0] BUS_WR_MASK = 32'h00FF_FFFF;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dsp_cfg_mgmt_responder.sv
// Type-1 config-space responder for the downstream switch port: answers
// cfg_mgmt reads/writes after a fixed latency and holds the bus-number registers.
module dsp_cfg_mgmt_responder
  import dsp_cfg_mgmt_responder_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [15:0] VENDOR_ID    = 16'h10EE,
  parameter logic [15:0] DEVICE_ID    = 16'h9038,
  parameter logic [31:0] CLASS_REV    = 32'h0604_0000
) (
  input  logic        dsp_user_clk,
  input  logic        sys_reset_n,
  input  logic [9:0]  cfg_mgmt_addr,
  input  logic [15:0] cfg_mgmt_function_number,
  input  logic        cfg_mgmt_write,
  input  logic [31:0] cfg_mgmt_write_data,
  input  logic [3:0]  cfg_mgmt_byte_enable,
  input  logic        cfg_mgmt_read,
  input  logic        cfg_mgmt_debug_access,
  output logic [31:0] cfg_mgmt_read_data,
  output logic        cfg_mgmt_read_write_done,
  output logic [7:0]  pri_bus_num,
  output logic [7:0]  sec_bus_num,
  output logic [7:0]  sub_bus_num,
  output logic [15:0] cmd_reg,
  output logic        bus_num_rdy,
  output logic        protocol_err
);

  localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [9:0]  r_addr;
  logic [15:0] r_func;
  logic        r_wr;
  logic        r_rd;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_done;
  logic [31:0] r_read_data;
  logic [7:0]  r_pri;
  logic [7:0]  r_sec;
  logic [7:0]  r_sub;
  logic [15:0] r_cmd;
  logic        r_bus_num_rdy;
  logic        r_protocol_err;

  logic        w_fn0;
  logic [31:0] w_be_mask;
  logic [31:0] w_rd_value;
  logic [31:0] w_bus_word;
  logic [31:0] w_bus_mask;
  logic [31:0] w_bus_new;
  logic [15:0] w_cmd_mask;
  logic [15:0] w_cmd_new;
  logic        w_unused;

  assign w_fn0      = (r_func == 16'h0000);
  assign w_be_mask  = be_to_mask(r_be);
  assign w_bus_word = {8'h00, r_sub, r_sec, r_pri};
  assign w_bus_mask = w_be_mask & BUS_WR_MASK;
  assign w_bus_new  = (w_bus_word & ~w_bus_mask) | (r_wdata & w_bus_mask);
  assign w_cmd_mask = CMD_WR_MASK & w_be_mask[15:0];
  assign w_cmd_new  = (r_cmd & ~w_cmd_mask) | (r_wdata[15:0] & w_cmd_mask);
  assign w_unused   = ^{cfg_mgmt_debug_access, w_bus_new[31:24]};

  always_comb begin
    w_rd_value = '0;
    case (r_addr)
      DW_ID:    w_rd_value = {DEVICE_ID, VENDOR_ID};
      DW_CMD:   w_rd_value = {16'h0000, r_cmd};
      DW_CLASS: w_rd_value = CLASS_REV;
      DW_HDR:   w_rd_value = HDR_TYPE1;
      DW_BUS:   w_rd_value = w_bus_word;
      default:  w_rd_value = '0;
    endcase
  end

  always_ff @(posedge dsp_user_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_func         <= '0;
      r_wr           <= 1'b0;
      r_rd           <= 1'b0;
      r_wdata        <= '0;
      r_be           <= '0;
      r_done         <= 1'b0;
      r_read_data    <= '0;
      r_pri          <= '0;
      r_sec          <= '0;
      r_sub          <= '0;
      r_cmd          <= '0;
      r_bus_num_rdy  <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_read_data   <= '0;
      r_bus_num_rdy <= (r_sec != 8'h00) && (r_sub != 8'h00);
      case (r_state)
        ST_IDLE: begin
          // While done is showing, the requester may still hold its request.
          if ((cfg_mgmt_read || cfg_mgmt_write) && !r_done) begin
            r_addr  <= cfg_mgmt_addr;
            r_func  <= cfg_mgmt_function_number;
            r_wr    <= cfg_mgmt_write;
            r_rd    <= cfg_mgmt_read;
            r_wdata <= cfg_mgmt_write_data;
            r_be    <= cfg_mgmt_byte_enable;
            r_cnt   <= CNT_LOAD;
            r_state <= ST_BUSY;
            if (cfg_mgmt_read && cfg_mgmt_write) begin
              r_protocol_err <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == 3'd0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
          if (w_fn0 && r_rd && !r_wr) begin
            r_read_data <= w_rd_value;
          end
          if (w_fn0 && r_wr && !r_rd) begin
            if (r_addr == DW_CMD) begin
              r_cmd <= w_cmd_new;
            end
            if (r_addr == DW_BUS) begin
              r_pri <= w_bus_new[7:0];
              r_sec <= w_bus_new[15:8];
              r_sub <= w_bus_new[23:16];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_mgmt_read_data       = r_read_data;
  assign cfg_mgmt_read_write_done = r_done;
  assign pri_bus_num              = r_pri;
  assign sec_bus_num              = r_sec;
  assign sub_bus_num              = r_sub;
  assign cmd_reg                  = r_cmd;
  assign bus_num_rdy              = r_bus_num_rdy;
  assign protocol_err             = r_protocol_err;

endmodule

// File: tb/tb_dsp_cfg_mgmt_responder.sv
// Scoreboard bench for dsp_cfg_mgmt_responder: expected read data is queued at
// request time and compared when the done pulse arrives.
module tb_dsp_cfg_mgmt_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic [9:0]  addr;
  logic [15:0] fn;
  logic        wr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rd;
  logic        dbg;
  logic [31:0] rdata;
  logic        done;
  logic [7:0]  pri, sec, sub;
  logic [15:0] cmd;
  logic        rdy;
  logic        perr;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  dsp_cfg_mgmt_responder #(.READ_LATENCY(LAT)) dut (
    .dsp_user_clk             (clk),
    .sys_reset_n              (rst_n),
    .cfg_mgmt_addr            (addr),
    .cfg_mgmt_function_number (fn),
    .cfg_mgmt_write           (wr),
    .cfg_mgmt_write_data      (wdata),
    .cfg_mgmt_byte_enable     (be),
    .cfg_mgmt_read            (rd),
    .cfg_mgmt_debug_access    (dbg),
    .cfg_mgmt_read_data       (rdata),
    .cfg_mgmt_read_write_done (done),
    .pri_bus_num              (pri),
    .sec_bus_num              (sec),
    .sub_bus_num              (sub),
    .cmd_reg                  (cmd),
    .bus_num_rdy              (rdy),
    .protocol_err             (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("read_data", rdata, e);
        $display("txn done: read_data=%08h expected=%08h", rdata, e);
      end
    end
  end

  // Issues one request at a negedge, waits for done, and drops the request
  // in the done cycle (or one cycle later when hold_extra is set).
  task automatic do_req(input logic [9:0] a, input logic [15:0] f, input logic w, input logic r,
                        input logic [31:0] d, input logic [3:0] b, input logic [31:0] exp_rd,
                        input bit hold_extra, input bit check_lat);
    int n;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    addr = a; fn = f; wr = w; rd = r; wdata = d; be = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 20);
    if (done !== 1'b1) chk("timeout", 32'd1, 32'd0);
    if (check_lat) chk("latency", 32'(n - 1), 32'(LAT + 1));
    if (hold_extra) @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    $display("txn addr=%0d fn=%0d wr=%0b rd=%0b data=%08h be=%h cycles=%0d", a, f, w, r, d, b, n - 1);
  endtask

  task automatic idle_rd_zero();
    @(negedge clk);
    chk("read_data_idle", rdata, 32'h0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; addr = '0; fn = '0; wr = 1'b0; rd = 1'b0; wdata = '0; be = '0; dbg = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus", {8'h0, sub, sec, pri}, 32'h0);
    chk("rst_cmd", {16'h0, cmd}, 32'h0);
    chk("rst_rdy", {31'h0, rdy}, 32'h0);
    chk("rst_perr", {31'h0, perr}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read-only identity registers and an unmapped address
    do_req(10'd0, 16'd0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h9038_10EE, 1'b0, 1'b1);
    idle_rd_zero();
    do_req(10'd2, 16'd0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0604_0000, 1'b0, 1'b1);
    do_req(10'd3, 16'd0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0001_0000, 1'b0, 1'b0);
    do_req(10'd5, 16'd0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);

    // Bus-number write and the registered ready flag
    do_req(10'd6, 16'd0, 1'b1, 1'b0, 32'hFF05_0201, 4'hF, 32'h0, 1'b0, 1'b1);
    chk("rdy_in_done_cycle", {31'h0, rdy}, 32'h0);
    repeat (2) @(negedge clk);
    chk("rdy_after_write", {31'h0, rdy}, 32'h1);
    chk("bus_regs", {8'h0, sub, sec, pri}, 32'h0005_0201);
    do_req(10'd6, 16'd0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0005_0201, 1'b0, 1'b0);

    // Command register byte-lane gating
    do_req(10'd1, 16'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'h1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cmd_be1", {16'h0, cmd}, 32'h0000_0007);
    do_req(10'd1, 16'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'h2, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cmd_be2", {16'h0, cmd}, 32'h0000_0407);
    do_req(10'd1, 16'd0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cmd_be0", {16'h0, cmd}, 32'h0000_0407);
    do_req(10'd1, 16'd0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0000_0407, 1'b0, 1'b0);

    // Partial bus write: only byte 1 (secondary) updated
    do_req(10'd6, 16'd0, 1'b1, 1'b0, 32'h1122_3344, 4'h2, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bus_partial", {8'h0, sub, sec, pri}, 32'h0005_3301);

    // Simultaneous read and write
    chk("perr_before", {31'h0, perr}, 32'h0);
    do_req(10'd6, 16'd0, 1'b1, 1'b1, 32'h0000_0000, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bus_after_rw", {8'h0, sub, sec, pri}, 32'h0005_3301);
    chk("perr_set", {31'h0, perr}, 32'h1);

    // Non-zero function: read 0, write ignored
    do_req(10'd0, 16'd1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    do_req(10'd6, 16'd1, 1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bus_fn1_write", {8'h0, sub, sec, pri}, 32'h0005_3301);

    // Request held one cycle past done: exactly one pulse
    d0 = done_cnt;
    do_req(10'd0, 16'd0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h9038_10EE, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk("single_done", 32'(done_cnt - d0), 32'd1);

    // Reset while busy on a bus write
    d0 = done_cnt;
    @(negedge clk);
    addr = 10'd6; fn = 16'd0; wr = 1'b1; rd = 1'b0; wdata = 32'h0007_0707; be = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; wr = 1'b0;
    #1;
    chk("rst_mid_perr", {31'h0, perr}, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_mid_bus", {8'h0, sub, sec, pri}, 32'h0);
    chk("rst_mid_cmd", {16'h0, cmd}, 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_mid_bus_after", {8'h0, sub, sec, pri}, 32'h0);
    do_req(10'd0, 16'd0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h9038_10EE, 1'b0, 1'b1);
    idle_rd_zero();

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
